// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: top-level game sequencer for the Flappy Bird design.
// Owns the IDLE/PLAY/PAUSE/LOST state, gates the physics datapath
// (reset, tick enable, flap strobe) and keeps the current and high scores.
// Optional feature macro: FLAPPY_AUTO_RESTART_EN (LOST returns to IDLE by
// itself once the hold time expires; flaps in LOST are ignored).
module flappy_game_ctrl #(
  parameter int SCORE_W         = 10,
  parameter int SCORE_MAX       = 999,
  parameter int LOST_HOLD_TICKS = 100,
  parameter int HOLD_W          = 7
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               tick,
  input  logic               flap_btn,
  input  logic               paused,
  input  logic               collide,
  input  logic               pass_pulse,
  output logic [1:0]         game_state,
  output logic               game_rst,
  output logic               game_en,
  output logic               flap_out,
  output logic               lost,
  output logic [SCORE_W-1:0] current_score,
  output logic [SCORE_W-1:0] highest_score
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOST  = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] LP_SCORE_MAX = SCORE_W'(SCORE_MAX);
  localparam logic [HOLD_W-1:0]  LP_HOLD_MAX  = HOLD_W'(LOST_HOLD_TICKS);

  state_t              r_state;
  logic [SCORE_W-1:0]  r_cur_score;
  logic [SCORE_W-1:0]  r_high_score;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_game_rst;
  logic                r_game_en;
  logic                r_flap_out;
  logic                r_lost;

  logic                r_flap_s1, r_flap_s2, r_flap_prev, r_flap_rise;
  logic                r_pause_s1, r_pause_s2;

  // Synchronize the asynchronous pushbutton and switch, then register the
  // flap rising edge so pin-to-rise latency is three clocks.
  // NOTE: two flops in series give the first one a full cycle to resolve
  // metastability before anything downstream looks at the value.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_flap_s1   <= 1'b0;
      r_flap_s2   <= 1'b0;
      r_flap_prev <= 1'b0;
      r_flap_rise <= 1'b0;
      r_pause_s1  <= 1'b0;
      r_pause_s2  <= 1'b0;
    end else begin
      r_flap_s1   <= flap_btn;
      r_flap_s2   <= r_flap_s1;
      r_flap_prev <= r_flap_s2;
      r_flap_rise <= r_flap_s2 & ~r_flap_prev;
      r_pause_s1  <= paused;
      r_pause_s2  <= r_pause_s1;
    end
  end

  // Game FSM with registered datapath controls and score keeping.
  // NOTE: non-blocking assignments only, so every register here samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= ST_IDLE;
      r_cur_score  <= '0;
      r_high_score <= '0;
      r_hold       <= '0;
      r_game_rst   <= 1'b1;
      r_game_en    <= 1'b0;
      r_flap_out   <= 1'b0;
      r_lost       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_game_en <= 1'b0;
          r_lost    <= 1'b0;
          if (r_flap_rise) begin
            // The flap that starts the run is also the bird's first flap.
            r_state     <= ST_PLAY;
            r_cur_score <= '0;
            r_flap_out  <= 1'b1;
            r_game_rst  <= 1'b0;
          end else begin
            r_flap_out <= 1'b0;
            r_game_rst <= 1'b1;
          end
        end

        ST_PLAY: begin
          r_game_rst <= 1'b0;
          if (collide) begin
            // Collision wins over a same-cycle pass; the high score compares
            // against the score as it stood before this cycle.
            r_state    <= ST_LOST;
            r_lost     <= 1'b1;
            r_game_en  <= 1'b0;
            r_flap_out <= 1'b0;
            r_hold     <= '0;
            if (r_cur_score > r_high_score) r_high_score <= r_cur_score;
          end else if (r_pause_s2) begin
            r_state    <= ST_PAUSE;
            r_game_en  <= 1'b0;
            r_flap_out <= 1'b0;
          end else begin
            r_game_en  <= tick;
            r_flap_out <= r_flap_rise;
            if (pass_pulse && (r_cur_score != LP_SCORE_MAX))
              r_cur_score <= r_cur_score + 1'b1;
          end
        end

        ST_PAUSE: begin
          // Datapath frozen; flaps, passes and collisions are dropped.
          r_game_rst <= 1'b0;
          r_game_en  <= 1'b0;
          r_flap_out <= 1'b0;
          if (!r_pause_s2) r_state <= ST_PLAY;
        end

        ST_LOST: begin
          r_game_rst <= 1'b0;
          r_game_en  <= 1'b0;
          r_flap_out <= 1'b0;
`ifdef FLAPPY_AUTO_RESTART_EN
          if (tick && (r_hold == LP_HOLD_MAX - 1'b1)) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_lost     <= 1'b0;
            r_game_rst <= 1'b1;
          end else if (tick && (r_hold != LP_HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
          end
`else
          if (r_flap_rise && (r_hold == LP_HOLD_MAX)) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_lost     <= 1'b0;
            r_game_rst <= 1'b1;
          end else if (tick && (r_hold != LP_HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
          end
`endif
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign game_state    = r_state;
  assign game_rst      = r_game_rst;
  assign game_en       = r_game_en;
  assign flap_out      = r_flap_out;
  assign lost          = r_lost;
  assign current_score = r_cur_score;
  assign highest_score = r_high_score;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed testbench for flappy_game_ctrl.
module tb_flappy_game_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       tick = 1'b0;
  logic       flap_btn = 1'b0;
  logic       paused = 1'b0;
  logic       collide = 1'b0;
  logic       pass_pulse = 1'b0;
  logic [1:0] game_state;
  logic       game_rst, game_en, flap_out, lost;
  logic [9:0] current_score, highest_score;

  int tests_run    = 0;
  int tests_failed = 0;

  flappy_game_ctrl dut (
    .clk          (clk),
    .clr          (clr),
    .tick         (tick),
    .flap_btn     (flap_btn),
    .paused       (paused),
    .collide      (collide),
    .pass_pulse   (pass_pulse),
    .game_state   (game_state),
    .game_rst     (game_rst),
    .game_en      (game_en),
    .flap_out     (flap_out),
    .lost         (lost),
    .current_score(current_score),
    .highest_score(highest_score)
  );

  always #5 clk = ~clk;

  // One clock: inputs set after this return are sampled at the next edge,
  // outputs are read 1 ns after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_flap();
    flap_btn = 1'b1;
    step(4);
    flap_btn = 1'b0;
    step(2);
  endtask

  task automatic do_tick(input int n = 1);
    repeat (n) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic do_pass(input int n);
    repeat (n) begin
      pass_pulse = 1'b1;
      step();
      pass_pulse = 1'b0;
      step();
    end
  endtask

  task automatic do_collide();
    collide = 1'b1;
    step();
    collide = 1'b0;
    step();
  endtask

  // From LOST back into a fresh PLAY run.
  task automatic restart();
    do_tick(100);
`ifndef FLAPPY_AUTO_RESTART_EN
    press_flap();
`endif
    press_flap();
    tests_run++;
    if (game_state !== 2'd1 || current_score !== 10'd0) begin
      tests_failed++;
      $display("FAIL restart: state=%0d score=%0d, expected state=1 score=0",
               game_state, current_score);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step(2);
    clr = 1'b0;
    tests_run++;
    if (game_state !== 2'd0 || game_rst !== 1'b1 || game_en !== 1'b0 ||
        flap_out !== 1'b0 || lost !== 1'b0 ||
        current_score !== 10'd0 || highest_score !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset: state=%0d rst=%b en=%b flap=%b lost=%b cur=%0d high=%0d, expected 0 1 0 0 0 0 0",
               game_state, game_rst, game_en, flap_out, lost, current_score, highest_score);
    end
  endtask

  task automatic test_start();
    flap_btn = 1'b1;
    step(3);
    tests_run++;
    if (game_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL start_latency: state=%0d after 3 clk, expected 0", game_state);
    end
    step();
    tests_run++;
    if (game_state !== 2'd1 || flap_out !== 1'b1 || game_rst !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_enter: state=%0d flap=%b rst=%b, expected 1 1 0",
               game_state, flap_out, game_rst);
    end
    step();
    tests_run++;
    if (flap_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_flap_single: flap_out=%b, expected 0", flap_out);
    end
    flap_btn = 1'b0;
    step(4);
  endtask

  task automatic test_play_tick_flap();
    tick = 1'b1;
    step();
    tick = 1'b0;
    tests_run++;
    if (game_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL play_tick: game_en=%b, expected 1", game_en);
    end
    step();
    tests_run++;
    if (game_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL play_tick_end: game_en=%b, expected 0", game_en);
    end
    // In PLAY the strobe appears one clock after the registered rise (4 clk).
    flap_btn = 1'b1;
    step(3);
    tests_run++;
    if (flap_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL play_flap_early: flap_out=%b, expected 0", flap_out);
    end
    step();
    tests_run++;
    if (flap_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL play_flap: flap_out=%b, expected 1", flap_out);
    end
    flap_btn = 1'b0;
    step(3);
  endtask

  task automatic test_score_and_lose();
    do_pass(5);
    tests_run++;
    if (current_score !== 10'd5) begin
      tests_failed++;
      $display("FAIL score5: current_score=%0d, expected 5", current_score);
    end
    do_collide();
    tests_run++;
    if (game_state !== 2'd3 || lost !== 1'b1 || highest_score !== 10'd5) begin
      tests_failed++;
      $display("FAIL lose1: state=%0d lost=%b high=%0d, expected 3 1 5",
               game_state, lost, highest_score);
    end
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      tests_run++;
      if (game_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL lost_en%0d: game_en=%b, expected 0", i, game_en);
      end
      step();
    end
  endtask

  // Hold time in LOST; three ticks already spent by the previous task.
  task automatic test_lost_hold();
`ifdef FLAPPY_AUTO_RESTART_EN
    do_tick(96);
    press_flap();
    tests_run++;
    if (game_state !== 2'd3) begin
      tests_failed++;
      $display("FAIL auto_hold99: state=%0d, expected 3", game_state);
    end
    do_tick(1);
    tests_run++;
    if (game_state !== 2'd0 || lost !== 1'b0 || game_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL auto_restart: state=%0d lost=%b rst=%b, expected 0 0 1",
               game_state, lost, game_rst);
    end
`else
    do_tick(47);
    press_flap();
    tests_run++;
    if (game_state !== 2'd3) begin
      tests_failed++;
      $display("FAIL hold50: state=%0d, expected 3", game_state);
    end
    do_tick(49);
    press_flap();
    tests_run++;
    if (game_state !== 2'd3) begin
      tests_failed++;
      $display("FAIL hold99: state=%0d, expected 3", game_state);
    end
    do_tick(1);
    press_flap();
    tests_run++;
    if (game_state !== 2'd0 || lost !== 1'b0 || game_rst !== 1'b1 ||
        current_score !== 10'd5) begin
      tests_failed++;
      $display("FAIL hold100: state=%0d lost=%b rst=%b cur=%0d, expected 0 0 1 5",
               game_state, lost, game_rst, current_score);
    end
`endif
    press_flap();
    tests_run++;
    if (game_state !== 2'd1 || current_score !== 10'd0) begin
      tests_failed++;
      $display("FAIL run2_start: state=%0d cur=%0d, expected 1 0",
               game_state, current_score);
    end
  endtask

  task automatic test_high_score();
    do_pass(3);
    do_collide();
    tests_run++;
    if (highest_score !== 10'd5 || current_score !== 10'd3) begin
      tests_failed++;
      $display("FAIL run2_high: high=%0d cur=%0d, expected 5 3",
               highest_score, current_score);
    end
    restart();
    do_pass(7);
    do_collide();
    tests_run++;
    if (highest_score !== 10'd7) begin
      tests_failed++;
      $display("FAIL run3_high: high=%0d, expected 7", highest_score);
    end
  endtask

  task automatic test_collide_priority();
    restart();
    do_pass(4);
    pass_pulse = 1'b1;
    collide    = 1'b1;
    step();
    pass_pulse = 1'b0;
    collide    = 1'b0;
    tests_run++;
    if (game_state !== 2'd3 || current_score !== 10'd4 || highest_score !== 10'd7) begin
      tests_failed++;
      $display("FAIL pass_collide: state=%0d cur=%0d high=%0d, expected 3 4 7",
               game_state, current_score, highest_score);
    end
    step();
  endtask

  task automatic test_saturation();
    restart();
    do_pass(1000);
    tests_run++;
    if (current_score !== 10'd999) begin
      tests_failed++;
      $display("FAIL saturate: current_score=%0d, expected 999", current_score);
    end
    do_collide();
    tests_run++;
    if (highest_score !== 10'd999) begin
      tests_failed++;
      $display("FAIL saturate_high: high=%0d, expected 999", highest_score);
    end
  endtask

  task automatic test_pause();
    restart();
    do_pass(2);
    paused = 1'b1;
    step(2);
    tests_run++;
    if (game_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL pause_latency: state=%0d, expected 1", game_state);
    end
    step();
    tests_run++;
    if (game_state !== 2'd2) begin
      tests_failed++;
      $display("FAIL pause_enter: state=%0d, expected 2", game_state);
    end
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      tests_run++;
      if (game_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL pause_en%0d: game_en=%b, expected 0", i, game_en);
      end
      step();
    end
    pass_pulse = 1'b1;
    collide    = 1'b1;
    step();
    pass_pulse = 1'b0;
    collide    = 1'b0;
    step();
    press_flap();
    tests_run++;
    if (game_state !== 2'd2 || current_score !== 10'd2 || flap_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_frozen: state=%0d cur=%0d flap=%b, expected 2 2 0",
               game_state, current_score, flap_out);
    end
    paused = 1'b0;
    step(3);
    tests_run++;
    if (game_state !== 2'd1) begin
      tests_failed++;
      $display("FAIL unpause: state=%0d, expected 1", game_state);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (flap_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL stale_flap%0d: flap_out=%b, expected 0", i, flap_out);
      end
      step();
    end
  endtask

  task automatic test_clr_mid_game();
    tests_run++;
    if (highest_score !== 10'd999) begin
      tests_failed++;
      $display("FAIL pre_clr_high: high=%0d, expected 999", highest_score);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests_run++;
    if (game_state !== 2'd0 || game_rst !== 1'b1 || lost !== 1'b0 ||
        current_score !== 10'd0 || highest_score !== 10'd0) begin
      tests_failed++;
      $display("FAIL clr_mid: state=%0d rst=%b lost=%b cur=%0d high=%0d, expected 0 1 0 0 0",
               game_state, game_rst, lost, current_score, highest_score);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_start();
    test_play_tick_flap();
    test_score_and_lose();
    test_lost_hold();
    test_high_score();
    test_collide_priority();
    test_saturation();
    test_pause();
    test_clr_mid_game();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
- Top-level game sequencer for the Flappy Bird design.
- Owns game state (IDLE/PLAY/PAUSE/LOST) and gates the `game` physics datapath: reset, tick enable and flap strobe.
- Keeps current and high score from datapath events, and drives `game_state`/`lost`/score to the VGA and seven-segment blocks.
- Runs on the 100 MHz master clock; consumes the 50 Hz game tick as a one-cycle enable.

Parameters:
- SCORE_W, 10, width of score counters.
- SCORE_MAX, 999, score saturation value (fits 7-seg decimal display).
- LOST_HOLD_TICKS, 100, game ticks to hold LOST before a restart is accepted (2 s at 50 Hz).
- HOLD_W, 7, width of hold counter; must hold LOST_HOLD_TICKS.

Ports:
- clk input 1 master clock, 100 MHz
- clr input 1 reset, synchronous, active-high
- tick input 1 one-clk pulse per game tick (50 Hz)
- flap_btn input 1 raw flap pushbutton, asynchronous
- paused input 1 pause switch level, asynchronous
- collide input 1 collision flag from datapath, level
- pass_pulse input 1 one-clk pulse, bird cleared a pillar
- game_state output 2 0=IDLE 1=PLAY 2=PAUSE 3=LOST
- game_rst output 1 hold-reset to physics datapath
- game_en output 1 tick gated to datapath (advance one step)
- flap_out output 1 one-clk flap strobe to datapath
- lost output 1 high in LOST
- current_score output SCORE_W score of current/last run
- highest_score output SCORE_W best score since clr

Behaviour:
- One clock (clk); reset clr is synchronous, active-high. All outputs registered.
- On clr: state=IDLE, current_score=0, highest_score=0, hold counter=0, synchronizers=0, game_rst=1, game_en=0, flap_out=0, lost=0.
- Input conditioning:
  - flap_btn and paused each pass through a 2-FF synchronizer.
  - flap_rise = synced flap & ~previous synced flap. Latency from pin to flap_rise is 3 clk.
- IDLE:
  - game_rst=1, game_en=0.
  - On flap_rise: go to PLAY, current_score<=0, flap_out pulses the same edge (first flap delivered).
- PLAY:
  - game_rst=0, game_en=tick.
  - flap_out=flap_rise, registered (1 clk after flap_rise).
  - pass_pulse: current_score+1, saturating at SCORE_MAX.
  - Priority within one cycle: collide > paused > pass_pulse.
  - collide=1: go to LOST; pass_pulse that same cycle is dropped.
  - On LOST entry, highest_score<=current_score if current_score>highest_score (compare the pre-entry value).
  - paused=1 with no collide: go to PAUSE.
- PAUSE:
  - game_en=0, flap_out=0, game_rst=0; datapath frozen.
  - Score unchanged; collide and pass_pulse ignored.
  - paused=0: return to PLAY.
  - flap_rise while paused is discarded, not queued.
- LOST:
  - lost=1, game_en=0, game_rst=0 (final frame stays displayed).
  - Hold counter clears on entry and increments on tick, saturating at LOST_HOLD_TICKS.
  - flap_rise with counter==LOST_HOLD_TICKS: go to IDLE, counter cleared. Earlier flaps are ignored.
  - paused has no effect.
- Score arithmetic:
  - Unsigned; no wrap. At SCORE_MAX further passes hold SCORE_MAX.
  - highest_score is only ever raised; cleared only by clr.
- game_state reflects the registered state; it updates the edge after the triggering input.
- clr mid-game: next cycle is IDLE with all outputs at reset values. highest_score is lost.

Optional Feature:
- Macro: FLAPPY_AUTO_RESTART_EN.
- Defined: in LOST, the cycle the hold counter reaches LOST_HOLD_TICKS, the FSM goes to IDLE automatically without flap; flap in LOST is ignored.
- Undefined: a flap_rise after the hold expires is required (default behaviour above).

Test Plan:
- clr 2 cycles -> game_state=0, game_rst=1, both scores 0. flap_btn pulse -> game_state=1 within 4 clk, flap_out single-cycle pulse, game_rst=0.
- In PLAY, 5 pass_pulse -> current_score=5. Then collide -> game_state=3, lost=1, highest_score=5, game_en stays 0 on subsequent ticks.
- Second run scoring 3 then collide -> highest_score remains 5. Third run scoring 7 -> highest_score=7.
- pass_pulse and collide in the same cycle at score 4 -> LOST, current_score=4. 1000 pass_pulses -> score holds at 999.
- paused=1 in PLAY -> game_state=2, game_en=0 across 3 ticks, flap ignored. paused=0 -> game_state=1, no stale flap_out.
- In LOST, flap after 50 ticks -> stays LOST. Flap after 100 ticks -> IDLE. With FLAPPY_AUTO_RESTART_EN, IDLE is reached at tick 100 with no flap.
